// File: rtl/bram_sp_param.sv
// Parametrised single-port RAM: byte-enable writes, selectable read-during-write
// behaviour, 1- or 2-stage registered output and a post-reset clear sequencer.
module bram_sp_param #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned WRITE_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cs,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   datain,
    output logic [DATA_WIDTH-1:0]   dataout,
    output logic                    dout_valid,
    output logic                    busy
);

    localparam int unsigned DEPTH          = 2 ** ADDR_WIDTH;
    localparam int unsigned NB             = DATA_WIDTH / 8;
    localparam int unsigned WM_WRITE_FIRST = 1;
    localparam int unsigned WM_NO_CHANGE   = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    busy_q;
    logic                    clear_we_c;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   old_word_c;
    logic [DATA_WIDTH-1:0]   merged_c;
    logic                    acc_c;
    logic                    mem_we_c;
    logic [ADDR_WIDTH-1:0]   mem_addr_c;
    logic [DATA_WIDTH-1:0]   mem_wdata_c;

    logic [DATA_WIDTH-1:0]   s1_data_q, s1_data_d;
    logic                    s1_valid_q, s1_valid_d;

    // Clear sequencer state register; busy is re-derived from the next state so it
    // falls on the same edge that enters READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != ST_READY);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clear_we_c = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clear_we_c = 1'b1;
                cnt_d      = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign acc_c = cs & ~busy_q & ~rst;

    // Byte merge of the incoming data over the currently stored word.
    always_comb begin
        old_word_c = mem[addr];
        merged_c   = old_word_c;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) begin
                merged_c[8*i +: 8] = datain[8*i +: 8];
            end
        end
    end

    // Write port arbitration: the clear sequencer owns the array until READY.
    always_comb begin
        mem_we_c    = 1'b0;
        mem_addr_c  = addr;
        mem_wdata_c = merged_c;
        if (!rst && clear_we_c) begin
            mem_we_c    = 1'b1;
            mem_addr_c  = cnt_q;
            mem_wdata_c = '0;
        end else if (acc_c && we) begin
            mem_we_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_addr_c] <= mem_wdata_c;
        end
    end

    // First output stage: data holds unless an access produces a result.
    always_comb begin
        s1_data_d  = s1_data_q;
        s1_valid_d = 1'b0;
        if (acc_c) begin
            if (!we) begin
                s1_data_d  = old_word_c;
                s1_valid_d = 1'b1;
            end else if (WRITE_MODE == WM_WRITE_FIRST) begin
                s1_data_d  = merged_c;
                s1_valid_d = 1'b1;
            end else if (WRITE_MODE == WM_NO_CHANGE) begin
                s1_data_d  = s1_data_q;
                s1_valid_d = 1'b0;
            end else begin
                s1_data_d  = old_word_c;
                s1_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s2_data_q;
        logic                  s2_valid_q;

        // Second stage simply delays the first; no stall path exists.
        always_ff @(posedge clk) begin
            if (rst) begin
                s2_data_q  <= '0;
                s2_valid_q <= 1'b0;
            end else begin
                s2_data_q  <= s1_data_q;
                s2_valid_q <= s1_valid_q;
            end
        end

        assign dataout    = s2_data_q;
        assign dout_valid = s2_valid_q;
    end else begin : g_lat1
        assign dataout    = s1_data_q;
        assign dout_valid = s1_valid_q;
    end

    assign busy = busy_q;

endmodule
